biquad_coeff_loader: RTL

Host-side writer for the biquad coefficient shift chain consumed by the incremental IIR stages. It holds a shadow bank of NCOEFF coefficients written from the register bus, then on commit streams them into the DSP B-cascade as `coeff_wr`/`coeff_dat` shifts. It finishes with a single `coeff_update` strobe so every DSP's active coefficient register changes on the same clock. One instance sits between the register block and each biquad's incremental section.

---
 rtl/biquad_coeff_loader_if.sv | 27 ++
 rtl/biquad_coeff_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/biquad_coeff_loader_if.sv
// Register-bus and coefficient-chain signals of biquad_coeff_loader.
// master = register block / host side, slave = loader.
interface biquad_coeff_loader_if #(
  parameter int unsigned CBITS = 18,
  parameter int unsigned ABITS = 4
);
  logic [ABITS-1:0] cfg_addr_i;
  logic [CBITS-1:0] cfg_dat_i;
  logic             cfg_wr_i;
  logic             commit_i;
  logic             busy_o;
  logic             done_o;
  logic             wr_drop_o;
  logic [CBITS-1:0] coeff_dat_o;
  logic             coeff_wr_o;
  logic             coeff_update_o;

  modport master (
    output cfg_addr_i, cfg_dat_i, cfg_wr_i, commit_i,
    input  busy_o, done_o, wr_drop_o, coeff_dat_o, coeff_wr_o, coeff_update_o
  );

  modport slave (
    input  cfg_addr_i, cfg_dat_i, cfg_wr_i, commit_i,
    output busy_o, done_o, wr_drop_o, coeff_dat_o, coeff_wr_o, coeff_update_o
  );
endinterface

// File: rtl/biquad_coeff_loader.sv
// Shadow coefficient bank that streams into a DSP B-cascade and then strobes a common update.
// Optional COEFF_AUTOCOMMIT_EN: an accepted write to index 0 also acts as a commit.
module biquad_coeff_loader #(
  parameter int unsigned NCOEFF = 12,
  parameter int unsigned CBITS  = 18,
  parameter int unsigned ABITS  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  biquad_coeff_loader_if.slave bus
);

  localparam int unsigned IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StUpdate, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic [CBITS-1:0] dat_q, dat_d;
  logic [CBITS-1:0] bank_q [NCOEFF];

  logic busy;
  logic addr_ok;
  logic wr_ok;
  logic commit_req;

  assign busy    = (state_q == StShift) || (state_q == StUpdate);
  // Extra bit keeps the compare correct when 2**ABITS == NCOEFF.
  assign addr_ok = {1'b0, bus.cfg_addr_i} < (ABITS + 1)'(NCOEFF);
  assign wr_ok   = bus.cfg_wr_i && addr_ok && !busy;

`ifdef COEFF_AUTOCOMMIT_EN
  assign commit_req = bus.commit_i || (wr_ok && (bus.cfg_addr_i == '0));
`else
  assign commit_req = bus.commit_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCOEFF; k++) bank_q[k] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NCOEFF; k++) begin
        if (bus.cfg_addr_i == ABITS'(k)) bank_q[k] <= bus.cfg_dat_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    dat_d   = dat_q;
    drop_d  = bus.cfg_wr_i && !wr_ok;
    unique case (state_q)
      StIdle: begin
        if (commit_req) begin
          state_d = StShift;
          idx_d   = IW'(NCOEFF - 1);
        end
      end
      StShift: begin
        // Data lags the shift strobe by one cycle; tail word goes first.
        dat_d = bank_q[idx_q];
        if (commit_req) pend_d = 1'b1;
        if (idx_q == '0) state_d = StUpdate;
        else             idx_d   = idx_q - IW'(1);
      end
      StUpdate: begin
        if (commit_req) pend_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (pend_q || commit_req) begin
          state_d = StShift;
          idx_d   = IW'(NCOEFF - 1);
          pend_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      dat_q   <= dat_d;
    end
  end

  // Strobes decode straight from the state flop so reset clears them asynchronously.
  assign bus.busy_o         = busy;
  assign bus.done_o         = (state_q == StDone);
  assign bus.coeff_wr_o     = (state_q == StShift);
  assign bus.coeff_update_o = (state_q == StUpdate);
  assign bus.wr_drop_o      = drop_q;
  assign bus.coeff_dat_o    = dat_q;

endmodule
